// File: rtl/coef_gen.sv
// coef_gen: attention-coefficient generator feeding the softmax stage.
// Accepts a serial stream of (src, dst) score pairs for one destination
// node, computes LeakyReLU(src + dst) saturated to DATA_WIDTH, and packs one
// row of NUM_OF_NODES coefficients that is held under a valid/ready handshake.
module coef_gen #(
    parameter int  DATA_WIDTH      = 8,
    parameter int  NUM_OF_NODES    = 5,
    parameter int  NEG_SHIFT       = 3,
    localparam int DATA_WIDTH_FLAT = NUM_OF_NODES * DATA_WIDTH,
    localparam int CNT_WIDTH       = $clog2(NUM_OF_NODES + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [DATA_WIDTH-1:0]      src_score_i,
    input  logic [DATA_WIDTH-1:0]      dst_score_i,
    input  logic                       in_last_i,
    output logic                       sm_valid_o,
    input  logic                       sm_ready_i,
    output logic [DATA_WIDTH_FLAT-1:0] coef_o,
    output logic [CNT_WIDTH-1:0]       coef_cnt_o,
    output logic                       ovf_o
);

    typedef enum logic {
        COLLECT,
        HOLD
    } state_t;

    // Empty slots carry the most negative value so softmax weights them at ~0.
    localparam logic [DATA_WIDTH-1:0] COEF_MIN  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] COEF_MAX  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [CNT_WIDTH-1:0]  LAST_SLOT = CNT_WIDTH'(NUM_OF_NODES - 1);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] coef_q [NUM_OF_NODES];
    logic [DATA_WIDTH-1:0] coef_d [NUM_OF_NODES];
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  ovf_q, ovf_d;
    logic [DATA_WIDTH-1:0] e_val;

    // LeakyReLU of the widened sum; negative branch is an arithmetic shift,
    // then the DATA_WIDTH+1 result is clipped back to DATA_WIDTH.
    function automatic logic [DATA_WIDTH-1:0] leaky_sat(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic signed [DATA_WIDTH:0] sum;
        logic signed [DATA_WIDTH:0] y;
        sum = $signed({a[DATA_WIDTH-1], a}) + $signed({b[DATA_WIDTH-1], b});
        y   = sum[DATA_WIDTH] ? (sum >>> NEG_SHIFT) : sum;
        if (y[DATA_WIDTH] != y[DATA_WIDTH-1]) begin
            return y[DATA_WIDTH] ? COEF_MIN : COEF_MAX;
        end
        return y[DATA_WIDTH-1:0];
    endfunction

    assign e_val      = leaky_sat(src_score_i, dst_score_i);
    assign in_ready_o = (state_q == COLLECT);
    assign sm_valid_o = (state_q == HOLD);
    assign coef_cnt_o = cnt_q;
    assign ovf_o      = ovf_q;

    // State, row slots, fill count and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            for (int unsigned k = 0; k < NUM_OF_NODES; k++) begin
                coef_q[k] <= COEF_MIN;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            for (int unsigned k = 0; k < NUM_OF_NODES; k++) begin
                coef_q[k] <= coef_d[k];
            end
        end
    end

    // Next-state: fill slots in COLLECT, release and clear the row in HOLD.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        for (int unsigned k = 0; k < NUM_OF_NODES; k++) begin
            coef_d[k] = coef_q[k];
        end
        case (state_q)
            COLLECT: begin
                if (in_valid_i) begin
                    for (int unsigned k = 0; k < NUM_OF_NODES; k++) begin
                        if (cnt_q == CNT_WIDTH'(k)) begin
                            coef_d[k] = e_val;
                        end
                    end
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                    if (in_last_i || (cnt_q == LAST_SLOT)) begin
                        state_d = HOLD;
                    end
                    if (!in_last_i && (cnt_q == LAST_SLOT)) begin
                        ovf_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (sm_ready_i) begin
                    state_d = COLLECT;
                    cnt_d   = '0;
                    for (int unsigned k = 0; k < NUM_OF_NODES; k++) begin
                        coef_d[k] = COEF_MIN;
                    end
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    // Pack the row with slot 0 in the most significant bits.
    always_comb begin
        coef_o = '0;
        for (int unsigned k = 0; k < NUM_OF_NODES; k++) begin
            coef_o[DATA_WIDTH*(NUM_OF_NODES-1-k) +: DATA_WIDTH] = coef_q[k];
        end
    end

endmodule

// File: tb/tb_coef_gen.sv
// tb_coef_gen: table-driven and scoreboard bench for coef_gen.
module tb_coef_gen;

    localparam int W  = 8;
    localparam int N  = 5;
    localparam int CW = $clog2(N + 1);

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid_i;
    logic           in_ready_o;
    logic [W-1:0]   src_score_i;
    logic [W-1:0]   dst_score_i;
    logic           in_last_i;
    logic           sm_valid_o;
    logic           sm_ready_i;
    logic [N*W-1:0] coef_o;
    logic [CW-1:0]  coef_cnt_o;
    logic           ovf_o;

    coef_gen #(.DATA_WIDTH(W), .NUM_OF_NODES(N), .NEG_SHIFT(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .src_score_i(src_score_i),
        .dst_score_i(dst_score_i),
        .in_last_i  (in_last_i),
        .sm_valid_o (sm_valid_o),
        .sm_ready_i (sm_ready_i),
        .coef_o     (coef_o),
        .coef_cnt_o (coef_cnt_o),
        .ovf_o      (ovf_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N*W-1:0] coef;
        logic [CW-1:0]  cnt;
        logic           ovf;
    } row_t;

    typedef struct {
        logic [W-1:0] src;
        logic [W-1:0] dst;
        logic         last;
        logic [W-1:0] exp;
    } vec_t;

    localparam logic [N*W-1:0] EMPTY_ROW = {N{8'h80}};

    int   checks = 0;
    int   errors = 0;
    int   rows_popped = 0;
    row_t sb[$];

    // reference row under construction
    logic [N*W-1:0] m_row;
    int             m_cnt;
    logic           m_ovf;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] model_e(input logic [W-1:0] s, input logic [W-1:0] d);
        int x;
        int y;
        x = int'($signed(s)) + int'($signed(d));
        if (x >= 0) y = x;
        else        y = -((-x + 7) / 8);
        if (y > 127)  y = 127;
        if (y < -128) y = -128;
        return W'(y);
    endfunction

    task automatic model_clear();
        m_row = EMPTY_ROW;
        m_cnt = 0;
    endtask

    task automatic model_push(input logic [W-1:0] s, input logic [W-1:0] d, input logic l);
        row_t r;
        m_row[W*(N-1-m_cnt) +: W] = model_e(s, d);
        m_cnt++;
        if (l || m_cnt == N) begin
            if (!l) m_ovf = 1'b1;
            r.coef = m_row;
            r.cnt  = CW'(m_cnt);
            r.ovf  = m_ovf;
            sb.push_back(r);
            model_clear();
        end
    endtask

    // Drive one pair and return just after the edge that consumed it.
    task automatic send_pair(input logic [W-1:0] s, input logic [W-1:0] d, input logic l);
        int t;
        t = 0;
        model_push(s, d, l);
        src_score_i = s;
        dst_score_i = d;
        in_last_i   = l;
        in_valid_i  = 1'b1;
        while (in_ready_o !== 1'b1) begin
            if (t >= 50) begin
                chk("in_ready_timeout", 64'(0), 64'(1));
                in_valid_i = 1'b0;
                return;
            end
            @(posedge clk); #1;
            t++;
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        sb.delete();
        model_clear();
        m_ovf = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_coef"},     64'(coef_o),     64'(EMPTY_ROW));
        chk({tag, "_cnt"},      64'(coef_cnt_o), 64'(0));
        chk({tag, "_sm_valid"}, 64'(sm_valid_o), 64'(0));
        chk({tag, "_in_ready"}, 64'(in_ready_o), 64'(1));
    endtask

    // Scoreboard: every output transfer pops and compares one expected row.
    always @(negedge clk) begin
        if (rst_n === 1'b0 && sm_valid_o === 1'b1 && sm_ready_i === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_row", 64'(coef_o), 64'(0));
            end else begin
                row_t r;
                r = sb.pop_front();
                chk("sb_coef", 64'(coef_o),     64'(r.coef));
                chk("sb_cnt",  64'(coef_cnt_o), 64'(r.cnt));
                chk("sb_ovf",  64'(ovf_o),      64'(r.ovf));
                rows_popped++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t vt[7];
        vt[0] = '{8'd3,   8'd4,   1'b0, 8'h07};
        vt[1] = '{8'd100, 8'd50,  1'b0, 8'h7F};
        vt[2] = '{8'h9C,  8'hC4,  1'b0, 8'hEC};
        vt[3] = '{8'hFF,  8'h00,  1'b0, 8'hFF};
        vt[4] = '{8'h80,  8'h80,  1'b1, 8'hE0};
        vt[5] = '{8'd10,  8'd5,   1'b0, 8'h0F};
        vt[6] = '{8'h00,  8'hF0,  1'b1, 8'hFE};

        rst_n = 1'b1; in_valid_i = 1'b0; sm_ready_i = 1'b0;
        src_score_i = '0; dst_score_i = '0; in_last_i = 1'b0;
        model_clear();
        m_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        chk_idle("reset");
        chk("reset_ovf", 64'(ovf_o), 64'(0));

        // full row, last on the 5th pair
        sm_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send_pair(vt[i].src, vt[i].dst, vt[i].last);
            chk("row1_slot", 64'(coef_o[W*(N-1-i) +: W]), 64'(vt[i].exp));
            chk("row1_cnt",  64'(coef_cnt_o), 64'(i + 1));
        end
        in_valid_i = 1'b0;
        chk("row1_coef",     64'(coef_o), 64'(40'h077FECFFE0));
        chk("row1_sm_valid", 64'(sm_valid_o), 64'(1));
        chk("row1_in_ready", 64'(in_ready_o), 64'(0));
        chk("row1_ovf",      64'(ovf_o), 64'(0));
        @(posedge clk); #1;
        chk_idle("row1_done");

        // short row, then backpressure with in_valid held high
        sm_ready_i = 1'b0;
        for (int i = 5; i < 7; i++) begin
            send_pair(vt[i].src, vt[i].dst, vt[i].last);
            chk("row2_slot", 64'(coef_o[W*(N-1-(i-5)) +: W]), 64'(vt[i].exp));
        end
        chk("row2_coef", 64'(coef_o), 64'(40'h0FFE808080));
        chk("row2_cnt",  64'(coef_cnt_o), 64'(2));
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            chk("bp_coef",     64'(coef_o), 64'(40'h0FFE808080));
            chk("bp_cnt",      64'(coef_cnt_o), 64'(2));
            chk("bp_in_ready", 64'(in_ready_o), 64'(0));
            chk("bp_sm_valid", 64'(sm_valid_o), 64'(1));
        end
        sm_ready_i = 1'b1;
        in_valid_i = 1'b0;
        @(posedge clk); #1;
        chk_idle("bp_release");

        // overflow: five pairs without in_last_i
        send_pair(8'd1, 8'd2, 1'b0);
        chk("next_row_start", 64'(coef_o), 64'(40'h0380808080));
        chk("next_row_cnt",   64'(coef_cnt_o), 64'(1));
        for (int i = 0; i < 4; i++) begin
            send_pair(8'(i * 20), 8'hF6, 1'b0);
        end
        in_valid_i = 1'b0;
        chk("ovf_close_valid", 64'(sm_valid_o), 64'(1));
        chk("ovf_set",         64'(ovf_o), 64'(1));
        @(posedge clk); #1;
        send_pair(8'd5, 8'd5, 1'b0);
        send_pair(8'hF0, 8'hF0, 1'b1);
        in_valid_i = 1'b0;
        @(posedge clk); #1;
        chk("ovf_sticky", 64'(ovf_o), 64'(1));
        do_reset();
        chk("ovf_cleared", 64'(ovf_o), 64'(0));

        // reset mid-row
        for (int i = 0; i < 3; i++) send_pair(8'(i + 1), 8'd7, 1'b0);
        in_valid_i = 1'b0;
        chk("midrow_cnt", 64'(coef_cnt_o), 64'(3));
        do_reset();
        chk_idle("rst_midrow");

        // reset mid-HOLD
        sm_ready_i = 1'b0;
        send_pair(8'd9, 8'd9, 1'b0);
        send_pair(8'd8, 8'd8, 1'b1);
        in_valid_i = 1'b0;
        @(posedge clk); #1;
        chk("hold_before_rst", 64'(sm_valid_o), 64'(1));
        do_reset();
        chk_idle("rst_hold");

        // back-to-back alternating 1-pair and 5-pair rows
        sm_ready_i  = 1'b1;
        rows_popped = 0;
        for (int r = 0; r < 8; r++) begin
            int n;
            n = (r % 2 == 1) ? 5 : 1;
            for (int p = 0; p < n; p++) begin
                send_pair(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), p == n - 1);
            end
        end
        in_valid_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("b2b_rows",     64'(rows_popped), 64'(8));
        chk("b2b_sb_empty", 64'(sb.size()), 64'(0));
        chk("b2b_ovf",      64'(ovf_o), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/coef_gen.md
# coef_gen

Attention-coefficient generator that sits directly upstream of the softmax stage. It accepts a serial stream of per-neighbour score pairs for one destination node. For each pair it computes e = LeakyReLU(src + dst), saturated to DATA_WIDTH. It packs one row of NUM_OF_NODES coefficients into the flat vector the softmax consumes and holds it under a valid/ready handshake.

## Interface
- DATA_WIDTH, 8: signed width of scores and of each output coefficient.
- NUM_OF_NODES, 5: coefficient slots per row.
- NEG_SHIFT, 3: LeakyReLU negative slope is 2^-NEG_SHIFT.
- DATA_WIDTH_FLAT (localparam): NUM_OF_NODES*DATA_WIDTH.
- CNT_WIDTH (localparam): $clog2(NUM_OF_NODES+1).

- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  synchronous, active-high reset (asserted when 1).
- in_valid_i  in  1  score pair valid.
- in_ready_o  out  1  block can accept a pair.
- src_score_i  in  DATA_WIDTH  signed a_src·Wh_i.
- dst_score_i  in  DATA_WIDTH  signed a_dst·Wh_j.
- in_last_i  in  1  final neighbour of the row.
- sm_valid_o  out  1  coef_o holds a complete row.
- sm_ready_i  in  1  softmax accepts the row.
- coef_o  out  DATA_WIDTH_FLAT  packed row; slot k occupies bits [DATA_WIDTH*(NUM_OF_NODES-k)-1 : DATA_WIDTH*(NUM_OF_NODES-1-k)], so slot 0 is in the MSBs.
- coef_cnt_o  out  CNT_WIDTH  number of filled slots in the current row.
- ovf_o  out  1  sticky flag: a row was force-closed without in_last_i.

## Operation
- States: COLLECT and HOLD. Reset enters COLLECT.
- Transfers:
  - Input transfer = in_valid_i && in_ready_o.
  - Output transfer = sm_valid_o && sm_ready_i.
- in_ready_o = (state == COLLECT), decoded from the registered state only. sm_valid_o = (state == HOLD).
- COLLECT, on an input transfer:
  - Compute sum = sext(src) + sext(dst), DATA_WIDTH+1 bits.
  - y = sum if sum ≥ 0; otherwise y = sum >>> NEG_SHIFT (arithmetic shift, rounds toward −inf).
  - Saturate y to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1].
  - Write y to slot coef_cnt_o and increment coef_cnt_o.
- Row close: occurs on the input transfer with in_last_i = 1, or on the transfer that fills slot NUM_OF_NODES−1, whichever comes first. The next state is HOLD.
  - If the row closes by filling the last slot while in_last_i = 0, set ovf_o. It stays set until reset.
  - in_last_i on exactly the NUM_OF_NODES-th pair is legal and does not set ovf_o.
- Unfilled slots hold −2^(DATA_WIDTH−1) (−128 for width 8), so softmax weights them at ≈0.
- HOLD:
  - coef_o and coef_cnt_o are stable.
  - Inputs are ignored (in_ready_o = 0).
  - On an output transfer: every slot returns to −2^(DATA_WIDTH−1), coef_cnt_o returns to 0, and the next state is COLLECT.
- Reset values: all slots −2^(DATA_WIDTH−1), coef_cnt_o 0, ovf_o 0, in_ready_o 1, sm_valid_o 0. A reset during HOLD discards the row; sm_valid_o is 0 in the following cycle.
- The block does not close empty rows. in_last_i is only meaningful with in_valid_i.

## Timing
- Throughput: one pair per cycle in COLLECT.
- Latency: a pair transferred at edge t appears in coef_o after edge t.
- Closing transfer at edge t: sm_valid_o = 1 and in_ready_o = 0 in the cycle after edge t.
- Output transfer at edge t: in_ready_o = 1 in the cycle after edge t. Minimum row period is therefore (pairs + 1) cycles.
- HOLD with sm_ready_i held low: coef_o is held indefinitely.
- in_valid_i asserted during HOLD: no transfer, no state change.

## Test plan
- Single full row, N=5, D=8, last on 5th pair, sm_ready_i=1; pairs (3,4), (100,50), (−100,−60), (−1,0), (−128,−128) → slots 7, 127, −20, −1, −32; coef_o = 0x07_7F_EC_FF_E0; sm_valid_o one cycle after the 5th transfer; ovf_o = 0.
- Short row: 2 pairs (10,5) and (0,−16), last on the 2nd → coef_o = 0x0F_FE_80_80_80, coef_cnt_o = 2.
- Backpressure: sm_ready_i held 0 for 10 cycles after row close, with in_valid_i held 1 → coef_o stable, in_ready_o = 0, no pair consumed. Release sm_ready_i → in_ready_o = 1 next cycle; the next row starts from slot 0 with all other slots at 0x80.
- Overflow: 5 pairs with in_last_i = 0 → row closes after the 5th, ovf_o = 1. ovf_o remains 1 through a subsequent clean row and clears only on rst_n = 1.
- Reset mid-row and mid-HOLD: rst_n pulsed after 3 pairs, and again while sm_valid_o = 1 → next cycle coef_o = 0x80_80_80_80_80, coef_cnt_o = 0, sm_valid_o = 0, in_ready_o = 1.
- Back-to-back rows: sm_ready_i tied to 1, in_valid_i continuous, alternating 1-pair and 5-pair rows → each row produces exactly one sm_valid_o cycle and no pair is lost or duplicated.
